ap_perf_monitor: RTL

Synthesizable, parametrised multi-channel performance monitor for HLS block-level handshakes (ap_start/ap_ready/ap_done/ap_continue). It is the hardware successor to the simulation-only module-status and loop monitors. It tracks NUM_CH kernels or sub-functions in parallel and accumulates per-channel transaction count, latency (last/min/max/sum), inter-start interval and ap_continue back-pressure stalls. Results are read out through a single-cycle-latency register port. It sits beside the HLS top, with the handshake signals tapped in parallel; it never drives them.

---
 rtl/ap_perf_monitor.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ap_perf_monitor.sv
// ap_perf_monitor: per-channel statistics for HLS block-level handshakes.
// Each channel runs a small FSM that follows ap_start/ap_done/ap_continue.
// The FSM feeds saturating latency, interval and stall statistics, which
// are read back through a one-cycle-latency register port. The monitor only
// observes the handshake; it never drives it.
module ap_perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int TXN_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              enable,
    input  logic              clear,
    input  logic              finish,
    input  logic              rd_req,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] overflow,
    output logic              frozen
);

    // Read fields are built at the wider of the two counter widths.
    localparam int XW = (CNT_W > TXN_W) ? CNT_W : TXN_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    logic              frozen_reg;
    logic              upd;
    logic [NUM_CH*XW-1:0] fld_all;
    logic [XW-1:0]     sel_fld;
    logic              rd_valid_reg;
    logic [CNT_W-1:0]  rd_data_reg;

    // Statistics change only while enabled and before the end-of-run freeze.
    assign upd = enable & ~frozen_reg;

    // Sticky end-of-run flag; the finish cycle itself still updates.
    always_ff @(posedge clock) begin
        if (reset) begin
            frozen_reg <= 1'b0;
        end else if (finish) begin
            frozen_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t            state_reg, state_next;
            logic              complete;
            logic              start_evt;
            logic              hs;
            logic [CNT_W-1:0]  lat_cnt_reg;
            logic [CNT_W-1:0]  ii_cnt_reg;
            logic              ii_seen_reg;
            logic [TXN_W-1:0]  txn_reg;
            logic [CNT_W-1:0]  lat_last_reg, lat_min_reg, lat_max_reg;
            logic [CNT_W-1:0]  lat_sum_reg, stall_reg, ii_last_reg;
            logic              ovf_reg;
            logic [TXN_W-1:0]  txn_inc;
            logic [CNT_W-1:0]  stall_inc;
            logic [CNT_W:0]    sum_wide;
            logic [CNT_W-1:0]  sum_sat;
            logic              ovf_hit;
            logic [XW-1:0]     fld;

            assign hs = ap_start[gi] & ap_ready[gi];

            // FSM state register.
            always_ff @(posedge clock) begin
                if (reset) begin
                    state_reg <= ST_IDLE;
                end else begin
                    state_reg <= state_next;
                end
            end

            // Next state plus completion / start-event strobes.
            always_comb begin
                state_next = state_reg;
                complete   = 1'b0;
                start_evt  = 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if (ap_start[gi]) begin
                            state_next = ST_RUN;
                            start_evt  = 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (ap_done[gi]) begin
                            complete = 1'b1;
                            if (!ap_continue[gi]) begin
                                state_next = ST_WAIT;
                            end else if (ap_start[gi]) begin
                                state_next = ST_RUN;
                                start_evt  = 1'b1;
                            end else begin
                                state_next = ST_IDLE;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (ap_continue[gi]) begin
                            if (ap_start[gi]) begin
                                state_next = ST_RUN;
                                start_evt  = 1'b1;
                            end else begin
                                state_next = ST_IDLE;
                            end
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end

            // Running latency: holds the latency a done in the current cycle
            // would report, so a done right after start reads 1.
            always_ff @(posedge clock) begin
                if (reset) begin
                    lat_cnt_reg <= '0;
                end else if (start_evt) begin
                    lat_cnt_reg <= {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (state_reg == ST_RUN && !ap_done[gi] && !(&lat_cnt_reg)) begin
                    lat_cnt_reg <= lat_cnt_reg + 1'b1;
                end
            end

            // Free-running interval counter and the "previous handshake" flag.
            always_ff @(posedge clock) begin
                if (reset) begin
                    ii_cnt_reg  <= '0;
                    ii_seen_reg <= 1'b0;
                end else begin
                    if (hs) begin
                        ii_cnt_reg <= {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (!(&ii_cnt_reg)) begin
                        ii_cnt_reg <= ii_cnt_reg + 1'b1;
                    end
                    if (clear) begin
                        ii_seen_reg <= 1'b0;
                    end else if (hs) begin
                        ii_seen_reg <= 1'b1;
                    end
                end
            end

            // Saturating next values and saturation detection.
            always_comb begin
                txn_inc   = (&txn_reg) ? txn_reg : txn_reg + 1'b1;
                stall_inc = (&stall_reg) ? stall_reg : stall_reg + 1'b1;
                sum_wide  = {1'b0, lat_sum_reg} + {1'b0, lat_cnt_reg};
                sum_sat   = sum_wide[CNT_W] ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];
                ovf_hit   = 1'b0;
                if (complete && ((&txn_inc) || (&lat_cnt_reg) || (&sum_sat))) begin
                    ovf_hit = 1'b1;
                end
                if (state_reg == ST_WAIT && (&stall_inc)) begin
                    ovf_hit = 1'b1;
                end
                if (hs && ii_seen_reg && (&ii_cnt_reg)) begin
                    ovf_hit = 1'b1;
                end
            end

            // Statistics registers; clear wins over a same-cycle update.
            always_ff @(posedge clock) begin
                if (reset || clear) begin
                    txn_reg      <= '0;
                    lat_last_reg <= '0;
                    lat_min_reg  <= '1;
                    lat_max_reg  <= '0;
                    lat_sum_reg  <= '0;
                    stall_reg    <= '0;
                    ii_last_reg  <= '0;
                    ovf_reg      <= 1'b0;
                end else if (upd) begin
                    if (complete) begin
                        txn_reg      <= txn_inc;
                        lat_last_reg <= lat_cnt_reg;
                        lat_sum_reg  <= sum_sat;
                        if (lat_cnt_reg < lat_min_reg) begin
                            lat_min_reg <= lat_cnt_reg;
                        end
                        if (lat_cnt_reg > lat_max_reg) begin
                            lat_max_reg <= lat_cnt_reg;
                        end
                    end
                    if (state_reg == ST_WAIT) begin
                        stall_reg <= stall_inc;
                    end
                    if (hs && ii_seen_reg) begin
                        ii_last_reg <= ii_cnt_reg;
                    end
                    if (ovf_hit) begin
                        ovf_reg <= 1'b1;
                    end
                end
            end

            // Field select for this channel, zero-extended.
            always_comb begin
                fld = '0;
                case (rd_sel)
                    3'd0: fld[TXN_W-1:0] = txn_reg;
                    3'd1: fld[CNT_W-1:0] = lat_last_reg;
                    3'd2: fld[CNT_W-1:0] = lat_min_reg;
                    3'd3: fld[CNT_W-1:0] = lat_max_reg;
                    3'd4: fld[CNT_W-1:0] = lat_sum_reg;
                    3'd5: fld[CNT_W-1:0] = stall_reg;
                    3'd6: fld[CNT_W-1:0] = ii_last_reg;
                    default: fld[3:0] = {frozen_reg, ovf_reg, state_reg};
                endcase
            end

            assign fld_all[gi*XW +: XW] = fld;
            assign busy[gi]     = (state_reg != ST_IDLE);
            assign overflow[gi] = ovf_reg;
        end
    endgenerate

    // Channel mux; an out-of-range channel leaves the field at zero.
    always_comb begin
        sel_fld = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == i[CH_W-1:0]) begin
                sel_fld = fld_all[i*XW +: XW];
            end
        end
    end

    // One-cycle read response register.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= rd_req;
            rd_data_reg  <= rd_req ? sel_fld[CNT_W-1:0] : '0;
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;
    assign frozen   = frozen_reg;

endmodule
